s32x_sdr_resp: RTL



---
 rtl/s32x_sdr_resp_if.sv | 33 +++
 rtl/s32x_sdr_resp.sv | 131 +++++++++++++
 2 files changed

// File: rtl/s32x_sdr_resp_if.sv
`default_nettype none
// ============================================================================
//  Module   : s32x_sdr_resp_if
//  Purpose  : SH-2 SDRAM request side plus generic req/ack memory port.
//  Revision : 1.0  initial release
// ============================================================================
interface s32x_sdr_resp_if;
    logic [16:0] sdr_a;
    logic [15:0] sdr_do;
    logic        sdr_cs;
    logic [1:0]  sdr_we;
    logic        sdr_rd;
    logic [15:0] sdr_di;
    logic        sdr_wait;
    logic [16:0] mem_a;
    logic [15:0] mem_do;
    logic [1:0]  mem_we;
    logic        mem_rd;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_di;

    modport slave (
        input  sdr_a, sdr_do, sdr_cs, sdr_we, sdr_rd, mem_ack, mem_di,
        output sdr_di, sdr_wait, mem_a, mem_do, mem_we, mem_rd, mem_req
    );

    modport master (
        output sdr_a, sdr_do, sdr_cs, sdr_we, sdr_rd, mem_ack, mem_di,
        input  sdr_di, sdr_wait, mem_a, mem_do, mem_we, mem_rd, mem_req
    );
endinterface
`default_nettype wire

// File: rtl/s32x_sdr_resp.sv
`default_nettype none
// ============================================================================
//  Module   : s32x_sdr_resp
//  Purpose  : Serves SH-2 SDRAM accesses on a req/ack memory port, holding
//             SDR_WAIT for at least MIN_WAIT clocks per access.
//  Revision : 1.0  initial release
// ============================================================================
module s32x_sdr_resp #(
    parameter int MIN_WAIT = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    s32x_sdr_resp_if.slave      bus
);
    localparam int c_CNT_W = $clog2(MIN_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 acked_q, acked_d;
    logic                 req_q, req_d;
    logic                 wait_q, wait_d;
    logic [15:0]          di_q, di_d;
    logic [16:0]          a_q, a_d;
    logic [15:0]          do_q, do_d;
    logic [1:0]           we_q, we_d;
    logic                 rd_q, rd_d;

    logic                 w_req;
    logic                 w_ack;
    logic                 w_expire;

    assign w_req    = bus.sdr_cs & (bus.sdr_rd | (|bus.sdr_we));
    assign w_ack    = req_q & bus.mem_ack;
    // Counter value 1 here becomes 0 at this edge, so WAIT may fall now.
    assign w_expire = (cnt_q <= c_CNT_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acked_d = acked_q;
        req_d   = req_q;
        wait_d  = wait_q;
        di_d    = di_q;
        a_d     = a_q;
        do_d    = do_q;
        we_d    = we_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    state_d = S_BUSY;
                    a_d     = bus.sdr_a;
                    do_d    = bus.sdr_do;
                    we_d    = bus.sdr_we;
                    rd_d    = (bus.sdr_we == 2'b00);
                    req_d   = 1'b1;
                    wait_d  = 1'b1;
                    acked_d = 1'b0;
                    cnt_d   = c_CNT_W'(MIN_WAIT);
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
                if (w_ack) begin
                    req_d   = 1'b0;
                    acked_d = 1'b1;
                    if (rd_q) begin
                        di_d = bus.mem_di;
                    end
                end
                if ((acked_q | w_ack) && w_expire) begin
                    wait_d  = 1'b0;
                    state_d = bus.sdr_cs ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                if (!bus.sdr_cs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                wait_d  = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acked_q <= 1'b0;
            req_q   <= 1'b0;
            wait_q  <= 1'b0;
            di_q    <= '0;
            a_q     <= '0;
            do_q    <= '0;
            we_q    <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acked_q <= acked_d;
            req_q   <= req_d;
            wait_q  <= wait_d;
            di_q    <= di_d;
            a_q     <= a_d;
            do_q    <= do_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
        end
    end

    assign bus.sdr_di   = di_q;
    assign bus.sdr_wait = wait_q;
    assign bus.mem_a    = a_q;
    assign bus.mem_do   = do_q;
    assign bus.mem_we   = we_q;
    assign bus.mem_rd   = rd_q;
    assign bus.mem_req  = req_q;
endmodule
`default_nettype wire
